// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: command encodings, PC width and sequencer states.
package cpu_pkg;

    localparam int PC_W = 9;

    typedef enum logic [2:0] {
        CMD_NEXT = 3'd0,
        CMD_BRA  = 3'd1,
        CMD_BRC  = 3'd2,
        CMD_BRZ  = 3'd3,
        CMD_CALL = 3'd4,
        CMD_RET  = 3'd5,
        CMD_HALT = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         overflow,
    output logic         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW:0]   count;
    logic          full;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign overflow  = push & full;
    assign underflow = pop & empty;
    assign pop_data  = mem[ptr - 1'b1];

    // ptr is the next write slot; once full it also points at the oldest entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch handshake, command decode and next-PC selection.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [8:0] RESET_PC    = 9'h000,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       fetch_req,
    output logic [8:0] fetch_addr,
    input  logic       fetch_ack,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic [7:0] offset,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic [8:0] pc,
    output logic       halted,
    output logic       stack_err
);

    state_t          state, state_next;
    logic [PC_W-1:0] pc_q, pc_next, seq, target;
    logic            push, pop;
    logic [PC_W-1:0] stk_data;
    logic            stk_empty, stk_ovf, stk_unf;

    assign seq    = pc_q + 1'b1;
    // one's-complement displacement: sign-extend, then add back the sign bit
    assign target = pc_q + {offset[7], offset} + {8'd0, offset[7]};

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .pop       (pop),
        .push_data (seq),
        .pop_data  (stk_data),
        .empty     (stk_empty),
        .overflow  (stk_ovf),
        .underflow (stk_unf)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        push       = 1'b0;
        pop        = 1'b0;
        fetch_req  = 1'b0;
        cmd_ready  = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_START: state_next = ST_FETCH;
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack)
                    state_next = ST_DECODE;
            end
            ST_DECODE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ST_FETCH;
                    case (cmd_t'(cmd))
                        CMD_BRA:  pc_next = target;
                        CMD_BRC:  pc_next = flag_c ? target : seq;
                        CMD_BRZ:  pc_next = flag_z ? target : seq;
                        CMD_CALL: begin
                            push    = 1'b1;
                            pc_next = target;
                        end
                        CMD_RET: begin
                            pop     = 1'b1;
                            pc_next = stk_empty ? seq : stk_data;
                        end
                        CMD_HALT: state_next = ST_HALT;
                        default:  pc_next = seq;
                    endcase
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_next = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_START;
            pc_q      <= RESET_PC;
            stack_err <= 1'b0;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            stack_err <= stack_err | stk_ovf | stk_unf;
        end
    end

    assign pc         = pc_q;
    assign fetch_addr = fetch_req ? pc_q : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a transaction-level PC/stack model checked every cycle.
module tb_pc_sequencer;

    localparam logic [2:0] C_NEXT = 3'd0, C_BRA = 3'd1, C_BRC = 3'd2, C_BRZ = 3'd3;
    localparam logic [2:0] C_CALL = 3'd4, C_RET = 3'd5, C_HALT = 3'd6, C_RSVD = 3'd7;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       fetch_req, cmd_ready, halted, stack_err;
    logic [8:0] fetch_addr, pc;
    logic       fetch_ack = 1'b0, cmd_valid = 1'b0, flag_c = 1'b0, flag_z = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic [7:0] offset = 8'd0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC    (9'h010),
        .STACK_DEPTH (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .offset     (offset),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .pc         (pc),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    typedef enum {P_START, P_FETCH, P_DECODE, P_HALT} phase_e;

    int     errors = 0;
    int     checks = 0;
    int     m_pc   = 'h010;
    int     m_stack[$];
    bit     m_err  = 1'b0;
    phase_e m_phase = P_START;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("fetch_req",  32'(fetch_req),  32'(m_phase == P_FETCH));
        chk("fetch_addr", 32'(fetch_addr), (m_phase == P_FETCH) ? m_pc : 0);
        chk("cmd_ready",  32'(cmd_ready),  32'(m_phase == P_DECODE));
        chk("halted",     32'(halted),     32'(m_phase == P_HALT));
        chk("pc",         32'(pc),         m_pc);
        chk("stack_err",  32'(stack_err),  32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_apply(input logic [2:0] c, input logic [7:0] off,
                                        input bit fc, input bit fz);
        logic [7:0] inv;
        int d, tgt, nxt;
        inv = ~off;
        d   = off[7] ? -int'(inv) : int'(off);
        tgt = (((m_pc + d) % 512) + 512) % 512;
        nxt = (m_pc + 1) % 512;
        m_phase = P_FETCH;
        case (c)
            C_BRA:  m_pc = tgt;
            C_BRC:  m_pc = fc ? tgt : nxt;
            C_BRZ:  m_pc = fz ? tgt : nxt;
            C_CALL: begin
                if (m_stack.size() == 4) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
                m_stack.push_back(nxt);
                m_pc = tgt;
            end
            C_RET: begin
                if (m_stack.size() == 0) begin
                    m_err = 1'b1;
                    m_pc  = nxt;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end
            C_HALT: m_phase = P_HALT;
            default: m_pc = nxt;
        endcase
    endfunction

    task automatic do_reset();
        resetn    = 1'b0;
        fetch_ack = 1'b0;
        cmd_valid = 1'b0;
        m_pc      = 'h010;
        m_stack.delete();
        m_err     = 1'b0;
        m_phase   = P_START;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        m_phase = P_FETCH;
    endtask

    // waits in FETCH with stray decoder activity that must be ignored
    task automatic fetch(input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            fetch_ack = 1'b0;
            cmd_valid = 1'b1;
            cmd       = C_BRA;
            offset    = 8'h33;
            tick();
        end
        cmd_valid = 1'b0;
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        m_phase   = P_DECODE;
    endtask

    task automatic decode(input logic [2:0] c, input logic [7:0] off, input bit fc,
                          input bit fz, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            fetch_ack = 1'b1;
            cmd_valid = 1'b0;
            tick();
        end
        fetch_ack = 1'b0;
        cmd_valid = 1'b1;
        cmd       = c;
        offset    = off;
        flag_c    = fc;
        flag_z    = fz;
        tick();
        cmd_valid = 1'b0;
        flag_c    = ~fc;
        flag_z    = ~fz;
        model_apply(c, off, fc, fz);
    endtask

    task automatic instr(input logic [2:0] c, input logic [7:0] off, input bit fc, input bit fz);
        fetch(0);
        decode(c, off, fc, fz, 0);
    endtask

    initial begin
        #1;
        do_reset();
        chk("lit_rst_addr", 32'(fetch_addr), 32'h010);

        fetch(3);
        decode(C_BRA, 8'h05, 1'b0, 1'b0, 2);
        chk("lit_bra05", 32'(pc), 32'h015);
        instr(C_BRA, 8'hFE, 1'b0, 1'b0);  chk("lit_braFE", 32'(pc), 32'h014);
        instr(C_BRA, 8'hFF, 1'b0, 1'b0);  chk("lit_braFF", 32'(pc), 32'h014);
        instr(C_BRA, 8'h80, 1'b0, 1'b0);  chk("lit_bra80", 32'(pc), 32'h195);
        instr(C_BRA, 8'h6A, 1'b0, 1'b0);  chk("lit_to1FF", 32'(pc), 32'h1FF);
        instr(C_NEXT, 8'h00, 1'b0, 1'b0); chk("lit_wrap", 32'(pc), 32'h000);
        instr(C_BRA, 8'hFD, 1'b0, 1'b0);  chk("lit_to1FE", 32'(pc), 32'h1FE);
        instr(C_BRA, 8'h05, 1'b0, 1'b0);  chk("lit_brawrap", 32'(pc), 32'h003);
        instr(C_BRA, 8'h1D, 1'b0, 1'b0);  chk("lit_to020", 32'(pc), 32'h020);
        instr(C_BRC, 8'h10, 1'b0, 1'b1);  chk("lit_brc_nt", 32'(pc), 32'h021);
        instr(C_BRC, 8'h10, 1'b1, 1'b0);  chk("lit_brc_t", 32'(pc), 32'h031);
        instr(C_BRZ, 8'hFD, 1'b0, 1'b1);  chk("lit_brz_t", 32'(pc), 32'h02F);
        instr(C_BRZ, 8'h10, 1'b1, 1'b0);  chk("lit_brz_nt", 32'(pc), 32'h030);
        instr(C_RSVD, 8'h40, 1'b1, 1'b1); chk("lit_rsvd", 32'(pc), 32'h031);
        instr(C_BRA, 8'h1F, 1'b0, 1'b0);  chk("lit_to050", 32'(pc), 32'h050);
        instr(C_CALL, 8'h10, 1'b0, 1'b0); chk("lit_call", 32'(pc), 32'h060);
        instr(C_RET, 8'h00, 1'b0, 1'b0);  chk("lit_ret", 32'(pc), 32'h051);
        chk("lit_err_clean", 32'(stack_err), 32'h0);

        for (int i = 0; i < 5; i++)
            instr(C_CALL, 8'h08, 1'b0, 1'b0);
        chk("lit_call5_pc", 32'(pc), 32'h079);
        chk("lit_call5_err", 32'(stack_err), 32'h1);
        instr(C_RET, 8'h00, 1'b0, 1'b0); chk("lit_ret1", 32'(pc), 32'h072);
        instr(C_RET, 8'h00, 1'b0, 1'b0); chk("lit_ret2", 32'(pc), 32'h06A);
        instr(C_RET, 8'h00, 1'b0, 1'b0); chk("lit_ret3", 32'(pc), 32'h062);
        instr(C_RET, 8'h00, 1'b0, 1'b0); chk("lit_ret4", 32'(pc), 32'h05A);
        instr(C_RET, 8'h00, 1'b0, 1'b0); chk("lit_ret5_unf", 32'(pc), 32'h05B);

        // reset while a fetch is outstanding
        fetch_ack = 1'b0;
        repeat (2) tick();
        do_reset();
        chk("lit_rst2_pc", 32'(pc), 32'h010);
        chk("lit_rst2_err", 32'(stack_err), 32'h0);

        fetch(1);
        decode(C_RET, 8'h00, 1'b0, 1'b0, 0);
        chk("lit_ret_empty_pc", 32'(pc), 32'h011);
        chk("lit_ret_empty_err", 32'(stack_err), 32'h1);
        instr(C_NEXT, 8'h00, 1'b0, 1'b0);
        instr(C_HALT, 8'h05, 1'b0, 1'b0);
        chk("lit_halt_pc", 32'(pc), 32'h012);
        chk("lit_halted", 32'(halted), 32'h1);

        for (int i = 0; i < 10; i++) begin
            fetch_ack = 1'b1;
            cmd_valid = 1'b1;
            cmd       = C_BRA;
            offset    = 8'h20;
            tick();
        end
        fetch_ack = 1'b0;
        cmd_valid = 1'b0;
        chk("lit_halt_hold_pc", 32'(pc), 32'h012);

        do_reset();
        instr(C_BRA, 8'h02, 1'b0, 1'b0);
        chk("lit_after_halt", 32'(pc), 32'h012);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 9-bit program counter and is the consumer of branch-target arithmetic.
- Issues instruction fetches to program memory over a req/ack handshake and accepts one decoded control command per fetched instruction.
- Computes the next PC: sequential, unconditional branch, conditional branch on C or Z, call, or return. Maintains a small return-address stack.
- Sits between program memory and the instruction decoder in the CPU core.

Parameters:
- RESET_PC, 9'h000, PC value loaded on reset.
- STACK_DEPTH, 4, return-stack entries (power of two, 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- fetch_req  out  1  fetch request; held until acked.
- fetch_addr  out  9  address to fetch; equals pc while fetch_req=1.
- fetch_ack  in  1  memory has captured the instruction; may be high in the same cycle as fetch_req.
- cmd_valid  in  1  decoder presents a command.
- cmd_ready  out  1  sequencer accepts a command this cycle.
- cmd  in  3  0=NEXT 1=BRA 2=BRC 3=BRZ 4=CALL 5=RET 6=HALT 7=reserved (treated as NEXT).
- offset  in  8  branch/call displacement, one's-complement encoded.
- flag_c  in  1  carry flag, sampled on command handshake.
- flag_z  in  1  zero flag, sampled on command handshake.
- pc  out  9  current program counter.
- halted  out  1  high in HALT state.
- stack_err  out  1  sticky; set on push overflow or pop underflow.

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC, state=START, stack pointer=0, stack_err=0.
  - All outputs low except pc. Stack contents are don't-care.
  - Reset mid-handshake aborts it; no fetch is reissued until START completes.
- States:
  - START: one cycle, no outputs asserted, then FETCH.
  - FETCH: fetch_req=1, fetch_addr=pc. On fetch_ack go to DECODE; otherwise stay in FETCH with the address stable.
  - DECODE: cmd_ready=1. On cmd_valid & cmd_ready, update pc as below. Go to HALT if cmd=HALT, else FETCH. Fetch latency is one cycle minimum per transition.
  - HALT: halted=1. All other handshake outputs are 0. Left only by reset.
- Target arithmetic:
  - target = pc + {offset[7],offset} + {8'd0,offset[7]}, truncated to 9 bits (mod 512).
  - Effective range is -127..+127. Offsets 0xFF and 0x00 both give target = pc.
  - seq = pc + 1 mod 512.
- PC update on handshake:
  - NEXT/reserved: pc=seq.
  - BRA: pc=target.
  - BRC: pc = flag_c ? target : seq.
  - BRZ: pc = flag_z ? target : seq.
  - CALL: push seq; pc=target.
  - RET: pop into pc.
  - HALT: pc unchanged.
- Return stack:
  - Circular, STACK_DEPTH entries, with a count register.
  - Push when full: overwrite the oldest entry, count stays full, stack_err=1.
  - Pop when empty: pc=seq, stack_err=1.
  - One push or pop per command; simultaneous push and pop cannot occur.
- Handshake rules:
  - cmd_valid outside DECODE is ignored.
  - fetch_ack outside FETCH is ignored.
  - fetch_addr is stable for the whole request.
- pc is registered and visible one cycle after the handshake.

Decomposition:
- Shared package cpu_pkg holds:
  - cmd encodings CMD_NEXT..CMD_HALT.
  - PC_W=9.
  - State encodings ST_START, ST_FETCH, ST_DECODE, ST_HALT.
- Natural sub-module: ret_stack (push/pop/data/full/empty/overflow/underflow, parameterised depth).
- Target arithmetic stays inline in pc_sequencer.

Test Plan:
- Reset with RESET_PC=0x010, then release -> one START cycle, then fetch_req=1 with fetch_addr=0x010. Delay fetch_ack by 3 cycles -> address held stable; cmd_ready=1 the cycle after ack.
- pc=0x010: BRA 0x05 -> pc=0x015; BRA 0xFE -> pc=0x014; BRA 0xFF -> pc=0x014 (self-target); BRA 0x80 -> pc=0x014-127=0x195.
- pc=0x1FF: NEXT -> pc=0x000. pc=0x1FE: BRA 0x05 -> pc=0x003.
- pc=0x020: BRC 0x10 with flag_c=0 -> pc=0x021; with flag_c=1 -> 0x031. BRZ with flag_z=1, offset 0xFD -> target = pc-2.
- pc=0x050: CALL 0x10 -> pc=0x060. RET -> pc=0x051. Five nested CALLs with depth 4 -> stack_err=1 and the fifth RET underflows to seq. A RET with an empty stack after reset -> pc=seq and stack_err=1.
- HALT command -> halted=1, fetch_req and cmd_ready stay 0 indefinitely. Pulse resetn low mid-FETCH -> pc=RESET_PC and the START->FETCH sequence restarts.
